// File: rtl/furv_bus_pkg.sv
// -----------------------------------------------------------------------------
// furv_bus_pkg
// Shared types and constants for the furv fetch/data bus arbiter.
//   state_e   : arbiter state (IDLE, GNT_I, GNT_D)
//   FETCH_SEL : byte-lane mask used for instruction fetches (always full word)
//   PORT_I/D  : encoding of the "last served" port
// -----------------------------------------------------------------------------
package furv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  localparam logic [3:0] FETCH_SEL = 4'b1111;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/furv_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// furv_bus_arbiter_if
// Bundles the three buses the arbiter touches:
//   i_*  : core instruction-fetch port (read-only, word address)
//   d_*  : core data port (read/write, byte lanes)
//   m_*  : shared memory bus (cyc/stb/we/sel/ack handshake)
// Modports:
//   master : the arbiter view (drives acks/errs/rdata back to the core and
//            drives the memory bus)
//   slave  : the environment view (core requesters plus memory slave)
// -----------------------------------------------------------------------------
interface furv_bus_arbiter_if;

  // fetch port
  logic        i_req;
  logic [29:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;

  // data port
  logic        d_req;
  logic        d_we;
  logic [29:0] d_addr;
  logic [3:0]  d_sel;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;

  // memory bus
  logic        m_cyc;
  logic        m_stb;
  logic        m_we;
  logic [29:0] m_addr;
  logic [3:0]  m_sel;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;

  modport master (
    input  i_req, i_addr,
    output i_rdata, i_ack, i_err,
    input  d_req, d_we, d_addr, d_sel, d_wdata,
    output d_rdata, d_ack, d_err,
    output m_cyc, m_stb, m_we, m_addr, m_sel, m_wdata,
    input  m_rdata, m_ack
  );

  modport slave (
    output i_req, i_addr,
    input  i_rdata, i_ack, i_err,
    output d_req, d_we, d_addr, d_sel, d_wdata,
    input  d_rdata, d_ack, d_err,
    input  m_cyc, m_stb, m_we, m_addr, m_sel, m_wdata,
    output m_rdata, m_ack
  );

endinterface

// File: rtl/furv_bus_watchdog.sv
// -----------------------------------------------------------------------------
// furv_bus_watchdog
// Per-transaction timeout counter for the bus arbiter.
//   clk, rst : clock, synchronous active-high reset
//   run      : a granted cycle is in progress and no ack arrived this cycle
//   clear    : transaction is over (or not running); counter returns to 0
//   expire   : combinational; high in the TIMEOUT-th consecutive run cycle
// TIMEOUT = 0 disables expiry entirely.
// -----------------------------------------------------------------------------
module furv_bus_watchdog #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expire
);

  // Count value seen during the last allowed cycle; the guard keeps the
  // TIMEOUT = 0 case from evaluating a negative constant.
  localparam logic [TW-1:0] LIMIT = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  logic [TW-1:0] wdog_q;
  logic [TW-1:0] wdog_d;

  always_comb begin
    wdog_d = wdog_q;
    if (clear) begin
      wdog_d = '0;
    end else if (run) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  assign expire = (TIMEOUT != 0) && run && (wdog_q == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

endmodule

// File: rtl/furv_bus_arbiter.sv
// -----------------------------------------------------------------------------
// furv_bus_arbiter
// Shares one single-ported memory bus between the furv fetch and data ports.
//   clk, rst : clock, synchronous active-high reset
//   bus      : furv_bus_arbiter_if.master (fetch port, data port, memory bus)
// Parameters:
//   ROUND_ROBIN : 1 = alternate on contention, 0 = data port always wins
//   TIMEOUT     : cycles without ack before an error is returned (0 = off)
//   TW          : watchdog counter width, TIMEOUT < 2**TW
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | bus free; arbitrate among requests sampled this cycle
// GNT_I | fetch port owns the bus until ack, timeout or abort
// GNT_D | data port owns the bus until ack, timeout or abort
//
// The bus outputs are combinational from state and the granted port so the
// address/data reach the slave in the first grant cycle. Every grant returns
// through IDLE, which keeps a request still high in its own ack cycle from
// being granted a second time.
// -----------------------------------------------------------------------------
module furv_bus_arbiter
  import furv_bus_pkg::*;
#(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned TW          = 8
) (
  input  logic              clk,
  input  logic              rst,
  furv_bus_arbiter_if.master bus
);

  state_e state_q;
  state_e state_d;
  logic   last_q;
  logic   last_d;

  logic   gnt_live;
  logic   wd_run;
  logic   wd_clear;
  logic   wd_expire;

  // Granted port still requesting; low in a grant state means abort.
  always_comb begin
    gnt_live = 1'b0;
    unique case (state_q)
      GNT_I:   gnt_live = bus.i_req;
      GNT_D:   gnt_live = bus.d_req;
      default: gnt_live = 1'b0;
    endcase
  end

  assign wd_run   = gnt_live & ~bus.m_ack;
  // Any cycle that is not a live, un-acked grant ends the transaction.
  assign wd_clear = ~wd_run | wd_expire;

  furv_bus_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .run    (wd_run),
    .clear  (wd_clear),
    .expire (wd_expire)
  );

  // Read data fans out unconditionally; only the acked port consumes it.
  assign bus.i_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;
  assign bus.m_stb   = bus.m_cyc;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    bus.m_cyc   = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_sel   = '0;
    bus.m_wdata = '0;
    bus.i_ack   = 1'b0;
    bus.i_err   = 1'b0;
    bus.d_ack   = 1'b0;
    bus.d_err   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_req && bus.d_req) begin
          // Round robin serves whichever port did not go last.
          state_d = (ROUND_ROBIN && (last_q == PORT_D)) ? GNT_I : GNT_D;
        end else if (bus.i_req) begin
          state_d = GNT_I;
        end else if (bus.d_req) begin
          state_d = GNT_D;
        end
      end

      GNT_I: begin
        if (bus.i_req) begin
          bus.m_cyc  = 1'b1;
          bus.m_addr = bus.i_addr;
          bus.m_sel  = FETCH_SEL;
          if (bus.m_ack) begin
            // Ack takes priority over a coincident timeout.
            bus.i_ack = 1'b1;
            state_d   = IDLE;
            last_d    = PORT_I;
          end else if (wd_expire) begin
            bus.i_err = 1'b1;
            state_d   = IDLE;
            last_d    = PORT_I;
          end
        end else begin
          state_d = IDLE;
        end
      end

      GNT_D: begin
        if (bus.d_req) begin
          bus.m_cyc   = 1'b1;
          bus.m_we    = bus.d_we;
          bus.m_addr  = bus.d_addr;
          bus.m_sel   = bus.d_sel;
          bus.m_wdata = bus.d_wdata;
          if (bus.m_ack) begin
            bus.d_ack = 1'b1;
            state_d   = IDLE;
            last_d    = PORT_D;
          end else if (wd_expire) begin
            bus.d_err = 1'b1;
            state_d   = IDLE;
            last_d    = PORT_D;
          end
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= PORT_D;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: doc/furv_bus_arbiter.md
Name: furv_bus_arbiter

Overview:
- Shares one single-ported memory bus between the core's instruction-fetch port and its data port.
- The memory bus is word-addressed, with byte lanes and a cyc/stb/we/sel/ack handshake.
- Grants are round-robin or data-first, and the grant is held until ack, error or abort.
- A per-transaction watchdog returns an error to the requester if the slave never acks.
- Sits between furv and the memory/peripheral interconnect.

Parameters:
- ROUND_ROBIN, 1: 1 = alternate grants on contention; 0 = data port always wins contention.
- TIMEOUT, 255: cycles without ack before error; 0 disables the watchdog.
- TW, 8: watchdog counter width; must satisfy TIMEOUT < 2**TW.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  fetch request; held until i_ack/i_err
- i_addr  in  30  fetch word address
- i_rdata  out  32  fetch data
- i_ack  out  1  fetch complete
- i_err  out  1  fetch timed out
- d_req  in  1  data request (core mem)
- d_we  in  1  data write
- d_addr  in  30  data word address
- d_sel  in  4  byte lanes
- d_wdata  in  32  write data
- d_rdata  out  32  read data
- d_ack  out  1  data complete
- d_err  out  1  data timed out
- m_cyc  out  1  bus cycle active
- m_stb  out  1  strobe (equals m_cyc)
- m_we  out  1  write
- m_addr  out  30  address
- m_sel  out  4  byte lanes (4'b1111 for fetch)
- m_wdata  out  32  write data (0 for fetch)
- m_rdata  in  32  read data
- m_ack  in  1  slave ack

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high, sampled on posedge clk.
- State machine: IDLE, GNT_I, GNT_D.
- Registered state: state, last (0 = fetch served last, 1 = data served last), wdog[TW-1:0].
- Reset values: state=IDLE, last=1 (fetch wins first contention), wdog=0.
- Output values in IDLE: m_cyc=m_stb=m_we=0, m_addr=0, m_sel=0, m_wdata=0, all ack/err=0.
- Master-side outputs are combinational from state and the granted requester's inputs. No extra latency on address or data.
- IDLE transitions:
  - Only i_req: go to GNT_I.
  - Only d_req: go to GNT_D.
  - Both, ROUND_ROBIN=1: grant the port not equal to last.
  - Both, ROUND_ROBIN=0: go to GNT_D.
- Latency: a request sampled high in IDLE at edge N gives m_cyc=1 in cycle N+1. Minimum transaction is 2 cycles (arbitrate, then ack cycle).
- In a GNT state:
  - m_cyc=m_stb=1 and the granted port is muxed onto the bus.
  - m_ack is routed combinationally to the granted port's ack.
  - m_rdata fans out to both i_rdata and d_rdata. Only the acked port may consume it.
- On m_ack:
  - Next state IDLE; last updated to the served port; wdog cleared.
  - There is always one IDLE cycle between grants, so a stale request held through its own ack cycle is never re-granted.
- Abort: if the granted port's req is low in a GNT cycle:
  - m_cyc is forced to 0 that cycle.
  - Next state IDLE; no ack or err is given; last is not updated.
- Watchdog (TIMEOUT>0):
  - wdog increments each GNT cycle without m_ack.
  - When wdog==TIMEOUT-1 and there is no m_ack: err pulses on the granted port for that cycle, m_cyc stays asserted, next state IDLE, wdog cleared, last updated.
  - A late m_ack arriving in IDLE is ignored.
- Simultaneous m_ack and timeout in the same cycle: ack wins, err stays 0.
- Reset mid-transaction: state becomes IDLE at that edge, so m_cyc=0 in the following cycle. No ack or err is generated.
- ack and err are never both high. At most one port sees ack or err in any cycle.
- m_addr, m_we, m_sel and m_wdata are don't-care when m_cyc=0, but are driven to 0 for determinism.

Decomposition:
- Package furv_bus_pkg:
  - state enum: IDLE, GNT_I, GNT_D.
  - Constants FETCH_SEL=4'b1111 and PORT_I=0 / PORT_D=1.
- Sub-module furv_bus_watchdog (params TIMEOUT, TW; ports clk, rst, run, clear, expire) holds the counter and expire compare.
- Arbiter FSM and bus mux stay in furv_bus_arbiter.

Test Plan:
- Single fetch: i_req=1, i_addr=30'h10; slave acks 1 cycle after m_cyc with m_rdata=32'h00000013.
  - Expect m_cyc in cycle 1, m_sel=4'hF, m_we=0.
  - Expect i_ack and i_rdata=32'h13 in cycle 2; d_ack stays 0.
- Contention, ROUND_ROBIN=1: i_req and d_req both held high, slave acks immediately.
  - Grant order I, D, I, D, with one IDLE cycle between each.
  - Repeat with ROUND_ROBIN=0: expect D, D, D and the fetch starved.
- Data write: d_req=1, d_we=1, d_addr=30'h100, d_sel=4'b0011, d_wdata=32'hDEADBEEF.
  - Expect the m_* mirror of these values, d_ack on m_ack, and i_ack=0.
- Timeout, TIMEOUT=4: d_req=1 and the slave never acks.
  - d_err is high exactly in the 4th GNT cycle, then state is IDLE.
  - m_ack=1 together with that 4th cycle gives d_ack=1 and d_err=0.
- Abort and reset:
  - Drop i_req 2 cycles into GNT_I: m_cyc=0 that cycle, no i_ack, and a pending d_req is granted after one IDLE cycle.
  - Assert rst during GNT_D: m_cyc=0 next cycle, no ack or err.
